// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on mem_ready with a bounded wait, traps on bad opcodes and overruns.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_source,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            state,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [ALU_CTRL_W-1:0] LP_ADD = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] LP_SUB = ALU_CTRL_W'(4'b0110);
  localparam logic [ALU_CTRL_W-1:0] LP_AND = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] LP_OR  = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] LP_SLT = ALU_CTRL_W'(4'b0111);
  localparam logic [ALU_CTRL_W-1:0] LP_NOR = ALU_CTRL_W'(4'b1100);

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_funct;
  logic [15:0] r_wait_cnt;
  logic        r_run;
  logic        r_illegal;
  logic        r_timeout;
  logic        w_waiting;
  logic        w_expire;
  logic        w_funct_ok;
  logic        w_bad_op;

  always_comb begin
    w_waiting  = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    // Expiry is judged on the cycle that would bring the count to TIMEOUT, so a
    // late mem_ready in that same cycle still completes the access.
    w_expire   = r_run && w_waiting && !mem_ready && (r_wait_cnt == LP_WAIT_LAST);
    w_funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010, 6'b100111};
    w_next_state = r_state;
    w_bad_op     = 1'b0;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'b100011, 6'b101011: w_next_state = S_MEM_ADDR;
          6'b000000: begin
            if (w_funct_ok) begin
              w_next_state = S_EXECUTE;
            end else begin
              w_next_state = S_TRAP;
              w_bad_op     = 1'b1;
            end
          end
          6'b000100: w_next_state = S_BRANCH;
          6'b000010: w_next_state = S_JUMP;
          6'b001000: w_next_state = S_ADDI_EXEC;
          default: begin
            w_next_state = S_TRAP;
            w_bad_op     = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  w_next_state = (opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next_state = S_FETCH;
      S_EXECUTE:   w_next_state = S_R_WB;
      S_ADDI_EXEC: w_next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next_state = S_FETCH;
      default:     w_next_state = S_TRAP;
    endcase
    if (w_expire) w_next_state = S_TRAP;
    // The first edge after reset release only arms the outputs; FETCH then runs.
    if (!r_run) begin
      w_next_state = r_state;
      w_bad_op     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_funct    <= 6'd0;
      r_wait_cnt <= 16'd0;
      r_run      <= 1'b0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_funct <= funct;
      if (w_bad_op) r_illegal <= 1'b1;
      if (w_expire) r_timeout <= 1'b1;
      if ((w_next_state != r_state) || mem_ready) begin
        r_wait_cnt <= 16'd0;
      end else if (w_waiting && r_run) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_control   = '0;
    instr_done    = 1'b0;
    if (r_run) begin
      alu_control = LP_ADD;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          i_or_d     = 1'b1;
          mem_write  = !w_expire;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          case (r_funct)
            6'b100010: alu_control = LP_SUB;
            6'b100100: alu_control = LP_AND;
            6'b100101: alu_control = LP_OR;
            6'b101010: alu_control = LP_SLT;
            6'b100111: alu_control = LP_NOR;
            default:   alu_control = LP_ADD;
          endcase
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_control   = LP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign mem_timeout = r_timeout;

endmodule
